// File: rtl/contact_result_buffer_if.sv
// contact_result_buffer_if: collider-result capture and host readback bus
interface contact_result_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH * 8);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          done;
  logic [31:0]   ret;
  logic [31:0]   cx;
  logic [31:0]   cy;
  logic [31:0]   cz;
  logic [31:0]   normalx;
  logic [31:0]   normaly;
  logic [31:0]   normalz;
  logic [31:0]   depth;
  logic          clear;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [CW-1:0] rec_count;
  logic [31:0]   pairs_seen;
  logic          busy;
  logic          full;
  logic          overflow;
  modport master (
    output done, ret, cx, cy, cz, normalx, normaly, normalz, depth, clear, rd_addr,
    input  rd_data, rec_count, pairs_seen, busy, full, overflow
  );
  modport slave (
    input  done, ret, cx, cy, cz, normalx, normaly, normalz, depth, clear, rd_addr,
    output rd_data, rec_count, pairs_seen, busy, full, overflow
  );
endinterface

// File: rtl/contact_result_buffer.sv
// contact_result_buffer: serialises sphere-pair contact results into an 8-word-per-record RAM
module contact_result_buffer #(
  parameter int DEPTH        = 16,
  parameter bit STORE_MISSES = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  contact_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH * 8);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t        r_state;
  state_t        w_next;
  logic          r_done_q;
  logic [2:0]    r_k;
  logic [CW-1:0] r_rec_count;
  logic [31:0]   r_pairs_seen;
  logic          r_overflow;
  logic [31:0]   r_rd_data;
  logic [31:0]   r_hold [8];
  logic [31:0]   r_ram [DEPTH*8];
  logic          w_event;
  logic          w_want;
  logic          w_busy;
  logic          w_full;
  logic          w_store;
  logic          w_drop;
  logic          w_last;
  logic [AW-1:0] w_waddr;
  assign w_event = bus.done & ~r_done_q & ~bus.clear;
  assign w_want  = (bus.ret != '0) | STORE_MISSES;
  assign w_busy  = r_state == WRITE;
  assign w_full  = r_rec_count == CW'(DEPTH);
  assign w_store = w_event & w_want & ~w_busy & ~w_full;
  assign w_drop  = w_event & w_want & (w_busy | w_full);
  assign w_last  = w_busy & (r_k == 3'd7);
  assign w_waddr = {r_rec_count[CW-2:0], r_k};
  assign bus.rd_data    = r_rd_data;
  assign bus.rec_count  = r_rec_count;
  assign bus.pairs_seen = r_pairs_seen;
  assign bus.busy       = w_busy;
  assign bus.full       = w_full;
  assign bus.overflow   = r_overflow;
  // Next state: clear abandons a record; accepted event starts one; word 7 ends it
  always_comb begin
    w_next = bus.clear ? IDLE : w_store ? WRITE : w_last ? IDLE : r_state;
  end
  // State register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // Edge detector keeps tracking done through clear so a held level never retriggers
  always_ff @(posedge clk) begin
    r_done_q <= rst ? 1'b0 : bus.done;
  end
  // Status counters, word counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst | bus.clear) begin
      r_rec_count  <= '0;
      r_pairs_seen <= '0;
      r_overflow   <= 1'b0;
      r_k          <= '0;
    end else begin
      r_k <= w_busy ? r_k + 3'd1 : 3'd0;
      if (w_event) r_pairs_seen <= r_pairs_seen + 32'd1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_last) r_rec_count <= r_rec_count + CW'(1);
    end
  end
  // Hold registers capture the record only when it will actually be written
  always_ff @(posedge clk) begin
    if (w_store) r_hold <= '{bus.cx, bus.cy, bus.cz, bus.normalx, bus.normaly, bus.normalz, bus.depth, r_pairs_seen};
  end
  // Record RAM write port, one word per busy cycle
  always_ff @(posedge clk) begin
    if (w_busy & ~bus.clear & ~rst) r_ram[w_waddr] <= r_hold[r_k];
  end
  // Registered read port; old data on a same-address write
  always_ff @(posedge clk) begin
    r_rd_data <= rst ? 32'd0 : r_ram[bus.rd_addr];
  end
endmodule

// File: tb/tb_contact_result_buffer.sv
// tb_contact_result_buffer: directed checks of capture, overflow, full, clear and readback
module tb_contact_result_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  always #5 clk = ~clk;
  contact_result_buffer_if #(.DEPTH(16)) bus ();
  contact_result_buffer #(.DEPTH(16), .STORE_MISSES(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] ret;
    logic [31:0] base;
    bit          exp_busy;
    int          exp_rec;
    int          exp_pairs;
  } vec_t;
  vec_t tv [5];
  logic [31:0] t1 [8];
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic setd(input logic [31:0] r, input logic [31:0] base);
    bus.ret     = r;
    bus.cx      = base;
    bus.cy      = base + 32'd1;
    bus.cz      = base + 32'd2;
    bus.normalx = base + 32'd3;
    bus.normaly = base + 32'd4;
    bus.normalz = base + 32'd5;
    bus.depth   = base + 32'd6;
  endtask
  task automatic pulse(input logic [31:0] r, input logic [31:0] base);
    setd(r, base);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    setd(32'd0, 32'hdead0000);
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask
  task automatic rd(input int a, output logic [31:0] d);
    bus.rd_addr = 7'(a);
    step();
    d = bus.rd_data;
  endtask
  task automatic chk_rec(input string nm, input int rec, input logic [31:0] base, input logic [31:0] idx);
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      rd(rec * 8 + k, d);
      chk(nm, d, k == 7 ? idx : base + 32'(k));
    end
  endtask
  task automatic chk_status(input string nm, input int rec, input int pairs, input bit b, input bit ovf);
    chk({nm, " rec_count"}, 32'(bus.rec_count), 32'(rec));
    chk({nm, " pairs_seen"}, bus.pairs_seen, 32'(pairs));
    chk({nm, " busy"}, 32'(bus.busy), 32'(b));
    chk({nm, " overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    tv[0] = '{32'd0,         32'h10000000, 1'b0, 0, 1};
    tv[1] = '{32'd5,         32'h20000000, 1'b1, 1, 2};
    tv[2] = '{32'h80000000,  32'h30000000, 1'b1, 2, 3};
    tv[3] = '{32'd0,         32'h40000000, 1'b0, 2, 4};
    tv[4] = '{32'd1,         32'h50000000, 1'b1, 3, 5};
    t1 = '{32'h3f000000, 32'h3f800000, 32'h40000000, 32'h40400000,
           32'h40800000, 32'h40a00000, 32'h3e800000, 32'h00000000};
    rst = 1'b1;
    bus.done = 1'b0;
    bus.clear = 1'b0;
    bus.rd_addr = '0;
    setd(32'd0, 32'd0);
    step(3);
    chk_status("reset", 0, 0, 1'b0, 1'b0);
    chk("reset full", 32'(bus.full), 32'd0);
    chk("reset rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    step(2);
    // single hit with the reference float payload, inputs scrambled after capture
    bus.ret = 32'd1;
    bus.cx = t1[0]; bus.cy = t1[1]; bus.cz = t1[2];
    bus.normalx = t1[3]; bus.normaly = t1[4]; bus.normalz = t1[5]; bus.depth = t1[6];
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    setd(32'd0, 32'hdead0000);
    for (int i = 0; i < 8; i++) begin
      chk("hit busy window", 32'(bus.busy), 32'd1);
      chk("hit rec_count during write", 32'(bus.rec_count), 32'd0);
      step();
    end
    chk_status("hit done", 1, 1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      rd(k, d);
      chk("hit readback", d, t1[k]);
    end
    // table of hits and misses
    do_clear();
    chk_status("after clear", 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pulse(tv[i].ret, tv[i].base);
      chk("vec busy", 32'(bus.busy), 32'(tv[i].exp_busy));
      step(8);
      chk_status("vec", tv[i].exp_rec, tv[i].exp_pairs, 1'b0, 1'b0);
      if (tv[i].exp_busy) chk_rec("vec record", tv[i].exp_rec - 1, tv[i].base, 32'(tv[i].exp_pairs - 1));
    end
    chk_rec("vec record0 intact", 0, 32'h20000000, 32'd1);
    // event while busy
    do_clear();
    pulse(32'd1, 32'h60000000);
    step(2);
    pulse(32'd1, 32'h70000000);
    step(5);
    chk_status("busy drop", 1, 2, 1'b0, 1'b1);
    chk_rec("busy drop record", 0, 32'h60000000, 32'd0);
    // clear in the middle of a write
    do_clear();
    chk("clear overflow", 32'(bus.overflow), 32'd0);
    pulse(32'd1, 32'h80000000);
    step(3);
    do_clear();
    chk_status("mid clear", 0, 0, 1'b0, 1'b0);
    step(2);
    chk("mid clear stays idle", 32'(bus.busy), 32'd0);
    pulse(32'd1, 32'h90000000);
    step(8);
    chk("post clear rec", 32'(bus.rec_count), 32'd1);
    chk_rec("post clear record", 0, 32'h90000000, 32'd0);
    // event coincident with clear is ignored
    setd(32'd1, 32'h91000000);
    bus.done = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.done = 1'b0;
    bus.clear = 1'b0;
    step();
    chk_status("clear+event", 0, 0, 1'b0, 1'b0);
    // held done produces one record
    setd(32'd1, 32'ha0000000);
    bus.done = 1'b1;
    step(50);
    chk_status("held done", 1, 1, 1'b0, 1'b0);
    chk_rec("held record", 0, 32'ha0000000, 32'd0);
    do_clear();
    step(3);
    chk_status("held through clear", 0, 0, 1'b0, 1'b0);
    bus.done = 1'b0;
    step();
    // fill to DEPTH then one more hit
    for (int i = 0; i < 16; i++) begin
      pulse(32'd1, 32'hb0000000 + 32'(i << 8));
      step(9);
      if (i == 14) chk("full before 16th", 32'(bus.full), 32'd0);
    end
    chk("full after 16th", 32'(bus.full), 32'd1);
    chk_status("full", 16, 16, 1'b0, 1'b0);
    pulse(32'd1, 32'hc0000000);
    chk("full drop busy", 32'(bus.busy), 32'd0);
    step(9);
    chk_status("full drop", 16, 17, 1'b0, 1'b1);
    chk("full stays", 32'(bus.full), 32'd1);
    chk_rec("record 15", 15, 32'hb0000f00, 32'h0000000f);
    chk_rec("record 0 after fill", 0, 32'hb0000000, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
